// File: rtl/run_sequencer.sv
// Operand sequencer for a downstream processor: queues operands, pulses the processor reset,
// runs each operand until a nonzero output or timeout, and returns results over valid/ready.
module run_sequencer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cpu_reset,
  output logic [DATA_W-1:0] cpu_input,
  input  logic [DATA_W-1:0] cpu_output,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] res_cycles,
  output logic              res_timeout,
  output logic              busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW:0]       FullCount = (AW + 1)'(DEPTH);
  localparam logic [RW-1:0]     RstLoad   = RW'(RST_CYCLES - 1);
  localparam logic [DATA_W-1:0] ToVal     = DATA_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRstp, StRun, StDone} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [RW-1:0]     rst_cnt;
  logic [DATA_W-1:0] run_cnt;
  logic [DATA_W-1:0] run_next;
  logic              push, pop;

  assign in_ready = (count != FullCount);
  assign push     = in_valid && in_ready;
  assign pop      = (state == StIdle) && (count != '0);
  assign busy     = (state != StIdle) || (count != '0);
  assign run_next = run_cnt + 1'b1;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= StIdle;
      rst_cnt     <= '0;
      run_cnt     <= '0;
      cpu_reset   <= 1'b1;
      cpu_input   <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          cpu_reset <= 1'b1;
          if (pop) begin
            cpu_input <= mem[rd_ptr];
            rst_cnt   <= RstLoad;
            state     <= StRstp;
          end
        end
        StRstp: begin
          if (rst_cnt == '0) begin
            run_cnt   <= '0;
            cpu_reset <= 1'b0;
            state     <= StRun;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        StRun: begin
          run_cnt <= run_next;
          // A nonzero answer takes priority over a timeout in the same cycle.
          if (cpu_output != '0) begin
            res_data    <= cpu_output;
            res_cycles  <= run_next;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            cpu_reset   <= 1'b1;
            state       <= StDone;
          end else if (run_next == ToVal) begin
            res_data    <= '0;
            res_cycles  <= ToVal;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            cpu_reset   <= 1'b1;
            state       <= StDone;
          end
        end
        StDone: begin
          cpu_reset <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
